ex_stage: RTL
=============

// Module: ex_stage
// PURPOSE
//   Execute stage of the 5-stage MIPS pipeline; sits between decode and memory access.
//   Registers the decode-to-execute bus and runs the 12-op ALU on the selected operands.
//   Issues the data SRAM request, forwards the EX result back to decode, and sends the
//   result to the memory stage. Holds HI/LO and a 32-iteration divider (DIV/DIVU);
//   stalls the pipeline while a divide runs.
// PARAMETERS
//   ID_TO_EX_WD   159  decode->EX bus width
//   EX_TO_MEM_WD  76   EX->MEM bus width
//   EX_TO_ID_WD   38   forwarding bus width {we, waddr[4:0], wdata[31:0]}
//   STALL_WD      6    stall vector width; bit 2 = EX register, bit 3 = MEM register
// PORTS
//   clk             in   1    clock
//   rst             in   1    reset, synchronous, active-high
//   stall           in   6    per-stage hold from stall controller (1 = Stop)
//   id_to_ex_bus    in   159  {pc[158:127], inst[126:95], alu_op[94:83], src1[82:80], src2[79:76],
//                             ram_en[75], ram_wen[74:71], rf_we[70], rf_waddr[69:65], sel_rf_res[64],
//                             rdata1[63:32], rdata2[31:0]}
//   ex_to_mem_bus   out  76   {pc[75:44], ram_en[43], ram_wen[42:39], sel_rf_res[38], rf_we[37],
//                             rf_waddr[36:32], ex_result[31:0]}
//   ex_to_id_bus    out  38   {rf_we, rf_waddr, ex_result} for decode-stage bypass
//   data_sram_en    out  1    data RAM enable
//   data_sram_wen   out  4    data RAM byte write enables
//   data_sram_addr  out  32   data RAM address (= ALU result)
//   data_sram_wdata out  32   store data (= rdata2)
//   stallreq_for_ex out  1    request to stall the pipeline (divide in progress)
// BEHAVIOUR
//   Input register: rst -> all zero; stall[2]=Stop & stall[3]=NoStop -> load zero (bubble);
//     stall[2]=NoStop -> load id_to_ex_bus; otherwise hold. Output buses are combinational from it.
//   Operands: src1 one-hot {sa zero-ext inst[10:6], pc, rdata1}; src2 one-hot
//     {imm zero-ext, 32'd8, imm sign-ext, rdata2}. No select bit set -> operand 0.
//   alu_op one-hot [11:0] = {add, sub, slt, sltu, and, nor, or, xor, sll, srl, sra, lui}.
//     add/sub: 32-bit wrap, no overflow trap. slt: signed. sltu: unsigned.
//     Shifts: src2 shifted by src1[4:0]. lui: {src2[15:0], 16'h0}. No op bit set -> 0.
//   MFHI/MFLO (op 0, funct 010000/010010): ex_result = HI/LO. Otherwise ex_result = ALU result.
//   MTHI/MTLO (op 0, funct 010001/010011): write rdata1 to HI/LO at the clock edge while the
//     instruction is in EX and stall[2]=NoStop.
//   data_sram_en = ram_en & ~stallreq_for_ex. data_sram_wen = ram_wen & {4{data_sram_en}}.
//   Divider FSM (DIV op 0 funct 011010, DIVU funct 011011):
//     IDLE: on a div in EX, latch |dividend| and |divisor| (raw values for DIVU) and the sign
//       flags, count = 0, go to BUSY. stallreq = 1 in this cycle.
//     BUSY: one restoring shift-subtract step per cycle; stallreq = 1. After the 32nd step,
//       write HI = remainder and LO = quotient with sign fix-up, then go to DONE.
//       Signed: quotient negated if signs differ; remainder takes the dividend's sign.
//     DONE: stallreq = 0; the div leaves EX. Return to IDLE on the first edge with
//       stall[2]=NoStop. A div held in DONE must not restart.
//   Latency: stallreq is high for 33 cycles per div, then HI/LO are valid in the next cycle.
//     A following MFHI/MFLO needs no extra interlock.
//   Divisor 0: LO = 32'hFFFF_FFFF, HI = dividend; same 33-cycle timing.
//   Reset, including mid-divide: FSM -> IDLE, count = 0, HI = LO = 0, stallreq = 0,
//     all output buses 0.
//   Bubble (all-zero register): rf_we = 0 and data_sram_en = 0; the FSM does not start.
// CONFIGURATION
//   EX_MULT_EN defined: MULT/MULTU (op 0 funct 011000/011001) write the 64-bit signed/unsigned
//     product to {HI, LO} in one cycle, with no stall.
//   EX_MULT_EN undefined: MULT/MULTU execute as NOPs; HI/LO are unchanged.
// TESTING
//   ori: rdata1=32'h0000_1200, inst imm 16'h0034, src1[0]/src2[3]/or ->
//     ex_result = 32'h0000_1234, ex_to_id_bus = {1, rt, 32'h0000_1234}.
//   DIV -7/2 -> stallreq high exactly 33 cycles; then LO = 32'hFFFF_FFFD, HI = 32'hFFFF_FFFF.
//   DIVU 32'hFFFF_FFFF/16 -> LO = 32'h0FFF_FFFF, HI = 32'hF; the next MFLO gives 32'h0FFF_FFFF.
//   DIV by 0 with dividend 32'h55 -> LO = 32'hFFFF_FFFF, HI = 32'h55; rst asserted at
//     BUSY step 10 -> stallreq = 0 and HI = LO = 0 on the next cycle.
//   sw, rdata1 + imm = 32'h100, rdata2 = 32'hCAFE -> data_sram_en = 1, wen = 4'hF,
//     addr = 32'h100, wdata = 32'hCAFE; stall[2]=Stop & stall[3]=NoStop -> next cycle
//     ex_to_mem_bus = 0.
//   EX_MULT_EN: MULT 32'hFFFF_FFFF x 2 -> HI = 32'hFFFF_FFFF, LO = 32'hFFFF_FFFE, no stall.
//     Without EX_MULT_EN, HI/LO are unchanged.

Source files
------------

// File: rtl/ex_stage.sv
// Execute stage of the 5-stage MIPS pipeline: ALU, HI/LO, a 32-step restoring divider and the data SRAM request.
// Define EX_MULT_EN to let MULT/MULTU write {HI, LO} in a single cycle; otherwise they behave as NOPs.
module ex_stage #(
   parameter int ID_TO_EX_WD  = 159,
   parameter int EX_TO_MEM_WD = 76,
   parameter int EX_TO_ID_WD  = 38,
   parameter int STALL_WD     = 6
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [STALL_WD-1:0]     stall,
   input  logic [ID_TO_EX_WD-1:0]  id_to_ex_bus,
   output logic [EX_TO_MEM_WD-1:0] ex_to_mem_bus,
   output logic [EX_TO_ID_WD-1:0]  ex_to_id_bus,
   output logic                    data_sram_en,
   output logic [3:0]              data_sram_wen,
   output logic [31:0]             data_sram_addr,
   output logic [31:0]             data_sram_wdata,
   output logic                    stallreq_for_ex
);

   typedef enum logic [1:0] {DIV_IDLE, DIV_BUSY, DIV_DONE} div_state_t;

   logic [ID_TO_EX_WD-1:0] id_ex_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         id_ex_q <= '0;
      end else if (stall[2] && !stall[3]) begin
         id_ex_q <= '0;
      end else if (!stall[2]) begin
         id_ex_q <= id_to_ex_bus;
      end
   end

   logic [31:0] pc, inst, rdata1, rdata2;
   logic [11:0] alu_op;
   logic [2:0]  src1;
   logic [3:0]  src2;
   logic        ram_en, rf_we, sel_rf_res;
   logic [3:0]  ram_wen;
   logic [4:0]  rf_waddr;

   assign pc         = id_ex_q[158:127];
   assign inst       = id_ex_q[126:95];
   assign alu_op     = id_ex_q[94:83];
   assign src1       = id_ex_q[82:80];
   assign src2       = id_ex_q[79:76];
   assign ram_en     = id_ex_q[75];
   assign ram_wen    = id_ex_q[74:71];
   assign rf_we      = id_ex_q[70];
   assign rf_waddr   = id_ex_q[69:65];
   assign sel_rf_res = id_ex_q[64];
   assign rdata1     = id_ex_q[63:32];
   assign rdata2     = id_ex_q[31:0];

   // Full SPECIAL-format decode, so reserved fields must be zero for a match.
   logic special, is_mfhi, is_mflo, is_mthi, is_mtlo, is_div, is_divu;
   assign special = (inst[31:26] == 6'b000000);
   assign is_mfhi = special && inst[25:16] == 10'd0 && inst[10:6] == 5'd0 && inst[5:0] == 6'b010000;
   assign is_mflo = special && inst[25:16] == 10'd0 && inst[10:6] == 5'd0 && inst[5:0] == 6'b010010;
   assign is_mthi = special && inst[20:6] == 15'd0 && inst[5:0] == 6'b010001;
   assign is_mtlo = special && inst[20:6] == 15'd0 && inst[5:0] == 6'b010011;
   assign is_div  = special && inst[15:6] == 10'd0 && inst[5:0] == 6'b011010;
   assign is_divu = special && inst[15:6] == 10'd0 && inst[5:0] == 6'b011011;

   logic [31:0] src1_val, src2_val;
   assign src1_val = ({32{src1[2]}} & {27'd0, inst[10:6]})
                   | ({32{src1[1]}} & pc)
                   | ({32{src1[0]}} & rdata1);
   assign src2_val = ({32{src2[3]}} & {16'd0, inst[15:0]})
                   | ({32{src2[2]}} & 32'd8)
                   | ({32{src2[1]}} & {{16{inst[15]}}, inst[15:0]})
                   | ({32{src2[0]}} & rdata2);

   logic [31:0] sum_res, diff_res, slt_res, sltu_res, sll_res, srl_res, sra_res, lui_res, alu_res;
   assign sum_res  = src1_val + src2_val;
   assign diff_res = src1_val - src2_val;
   assign slt_res  = {31'd0, $signed(src1_val) < $signed(src2_val)};
   assign sltu_res = {31'd0, src1_val < src2_val};
   assign sll_res  = src2_val << src1_val[4:0];
   assign srl_res  = src2_val >> src1_val[4:0];
   assign sra_res  = $signed(src2_val) >>> src1_val[4:0];
   assign lui_res  = {src2_val[15:0], 16'h0000};

   assign alu_res = ({32{alu_op[11]}} & sum_res)
                  | ({32{alu_op[10]}} & diff_res)
                  | ({32{alu_op[9]}}  & slt_res)
                  | ({32{alu_op[8]}}  & sltu_res)
                  | ({32{alu_op[7]}}  & (src1_val & src2_val))
                  | ({32{alu_op[6]}}  & ~(src1_val | src2_val))
                  | ({32{alu_op[5]}}  & (src1_val | src2_val))
                  | ({32{alu_op[4]}}  & (src1_val ^ src2_val))
                  | ({32{alu_op[3]}}  & sll_res)
                  | ({32{alu_op[2]}}  & srl_res)
                  | ({32{alu_op[1]}}  & sra_res)
                  | ({32{alu_op[0]}}  & lui_res);

   logic [31:0] hi_q, lo_q, ex_result;
   assign ex_result = is_mfhi ? hi_q : (is_mflo ? lo_q : alu_res);

   // Divider: one IDLE cycle to latch magnitudes, then 32 BUSY steps; DONE waits for EX to advance.
   div_state_t  div_state_q, div_state_d;
   logic [4:0]  div_count_q;
   logic [31:0] rem_q, quo_q, dvs_q;
   logic        neg_quo_q, neg_rem_q;
   logic        div_start, div_step, div_finish;

   always_ff @(posedge clk) begin
      if (rst) div_state_q <= DIV_IDLE;
      else     div_state_q <= div_state_d;
   end

   always_comb begin
      div_state_d     = div_state_q;
      stallreq_for_ex = 1'b0;
      div_start       = 1'b0;
      div_step        = 1'b0;
      div_finish      = 1'b0;
      case (div_state_q)
         DIV_IDLE: begin
            if (is_div || is_divu) begin
               stallreq_for_ex = 1'b1;
               div_start       = 1'b1;
               div_state_d     = DIV_BUSY;
            end
         end
         DIV_BUSY: begin
            stallreq_for_ex = 1'b1;
            div_step        = 1'b1;
            if (div_count_q == 5'd31) begin
               div_finish  = 1'b1;
               div_state_d = DIV_DONE;
            end
         end
         DIV_DONE: begin
            if (!stall[2]) div_state_d = DIV_IDLE;
         end
         default: div_state_d = DIV_IDLE;
      endcase
   end

   logic [32:0] shifted, trial;
   logic        fits;
   logic [31:0] rem_next, quo_next, quo_final, rem_final;
   assign shifted   = {rem_q, quo_q[31]};
   assign trial     = shifted - {1'b0, dvs_q};
   assign fits      = !trial[32];
   assign rem_next  = fits ? trial[31:0] : shifted[31:0];
   assign quo_next  = {quo_q[30:0], fits};
   assign quo_final = (dvs_q == 32'd0) ? 32'hFFFF_FFFF : (neg_quo_q ? -quo_next : quo_next);
   assign rem_final = neg_rem_q ? -rem_next : rem_next;

   always_ff @(posedge clk) begin
      if (rst) begin
         div_count_q <= '0;
         rem_q       <= '0;
         quo_q       <= '0;
         dvs_q       <= '0;
         neg_quo_q   <= 1'b0;
         neg_rem_q   <= 1'b0;
      end else if (div_start) begin
         div_count_q <= '0;
         rem_q       <= '0;
         quo_q       <= (is_div && rdata1[31]) ? -rdata1 : rdata1;
         dvs_q       <= (is_div && rdata2[31]) ? -rdata2 : rdata2;
         neg_quo_q   <= is_div && (rdata1[31] ^ rdata2[31]);
         neg_rem_q   <= is_div && rdata1[31];
      end else if (div_step) begin
         div_count_q <= div_count_q + 5'd1;
         rem_q       <= rem_next;
         quo_q       <= quo_next;
      end
   end

`ifdef EX_MULT_EN
   logic        is_mult, is_multu;
   logic [63:0] product;
   assign is_mult  = special && inst[15:6] == 10'd0 && inst[5:0] == 6'b011000;
   assign is_multu = special && inst[15:6] == 10'd0 && inst[5:0] == 6'b011001;
   assign product  = is_mult
                   ? $signed({{32{rdata1[31]}}, rdata1}) * $signed({{32{rdata2[31]}}, rdata2})
                   : {32'd0, rdata1} * {32'd0, rdata2};
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         hi_q <= '0;
         lo_q <= '0;
      end else if (div_finish) begin
         hi_q <= rem_final;
         lo_q <= quo_final;
      end else if (!stall[2]) begin
         if (is_mthi) hi_q <= rdata1;
         if (is_mtlo) lo_q <= rdata1;
`ifdef EX_MULT_EN
         if (is_mult || is_multu) {hi_q, lo_q} <= product;
`endif
      end
   end

   assign data_sram_en    = ram_en & ~stallreq_for_ex;
   assign data_sram_wen   = ram_wen & {4{data_sram_en}};
   assign data_sram_addr  = alu_res;
   assign data_sram_wdata = rdata2;

   assign ex_to_mem_bus = {pc, ram_en, ram_wen, sel_rf_res, rf_we, rf_waddr, ex_result};
   assign ex_to_id_bus  = {rf_we, rf_waddr, ex_result};

endmodule
